// File: rtl/sar_search.sv
// Binary-search engine driving a magnitude comparator's b operand.
// Define SAR_SEARCH_ONEHOT_CHECK_EN to abort on non-one-hot flags.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             alb,
    input  logic             aeb,
    input  logic             agb,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    localparam logic [WIDTH:0]   MAX_B = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO  = '0;

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   lo_n, hi_n, mid;
    logic             upd, miss, bad;

`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        found_d  = found_q;
        done_d   = 1'b0;
        lo_n     = lo_q;
        hi_n     = hi_q;
        mid      = '0;
        upd      = 1'b0;
        miss     = 1'b0;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
        err_d    = err_q;
        bad      = ~((alb ^ aeb ^ agb) & ~(alb & aeb & agb));
`else
        bad      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = MAX_B;
                    probe_d = ONES >> 1;
                    found_d = 1'b0;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (bad) begin
                    done_d  = 1'b1;
                    found_d = 1'b0;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
                    err_d   = 1'b1;
`endif
                    state_d = IDLE;
                end else if (aeb) begin
                    result_d = probe_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (agb) begin
                    if (probe_q == ONES) begin
                        miss = 1'b1;
                    end else begin
                        lo_n = {1'b0, probe_q} + 1'b1;
                        upd  = 1'b1;
                    end
                end else if (alb) begin
                    if (probe_q == ZERO) begin
                        miss = 1'b1;
                    end else begin
                        hi_n = {1'b0, probe_q} - 1'b1;
                        upd  = 1'b1;
                    end
                end
                // no flag: hold bounds and probe so a slow comparator settles
                if (upd) begin
                    if (lo_n > hi_n) begin
                        miss = 1'b1;
                    end else begin
                        mid     = (lo_n + hi_n) >> 1;
                        lo_d    = lo_n;
                        hi_d    = hi_n;
                        probe_d = mid[WIDTH-1:0];
                    end
                end
                if (miss) begin
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            found_q  <= found_d;
            done_q   <= done_d;
        end
    end

`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign probe  = probe_q;
    assign busy   = (state_q == SEARCH);
    assign done   = done_q;
    assign found  = found_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural comparator.
// Modes: 0 ideal, 1 agb stuck, 2 alb stuck, 3 all flags low.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       alb, aeb, agb;
    logic [3:0] probe, result;
    logic       busy, done, found, err;

    logic [3:0] a_h = 4'd0;
    int         mode = 0;

    int checks = 0;
    int failures = 0;

    sar_search #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alb(alb), .aeb(aeb), .agb(agb),
        .probe(probe), .busy(busy), .done(done),
        .found(found), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    always_comb begin
        alb = 1'b0;
        aeb = 1'b0;
        agb = 1'b0;
        case (mode)
            0: begin
                alb = (a_h < probe);
                aeb = (a_h == probe);
                agb = (a_h > probe);
            end
            1: agb = 1'b1;
            2: alb = 1'b1;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]      a;
        int              m;
        bit              noisy;
        int              k;
        bit              f;
        logic [3:0]      r;
        bit              cs;
        logic [0:4][3:0] s;
    } vec_t;

    logic [3:0] seq [0:7];
    int         k_o;

    task automatic run(input logic [3:0] a, input int m, input bit noisy);
        a_h  = a;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = noisy;
        seq[0] = probe;
        k_o = 0;
        chk("busy_launch", busy, 1);
        while (!done && k_o < 20) begin
            @(posedge clk);
            #1;
            k_o++;
            if (!done && k_o < 8) seq[k_o] = probe;
        end
        start = 1'b0;
        if (!done) chk("timeout", 0, 1);
    endtask

    vec_t vecs [0:18];
    int   kt [0:15] = '{4, 3, 4, 2, 4, 3, 4, 1, 4, 3, 4, 2, 4, 3, 4, 5};

    initial begin
        vecs[0] = '{4'd7, 0, 1'b0, 1, 1'b1, 4'd7, 1'b0, '0};
        for (int i = 0; i < 16; i++) begin
            vecs[i+1] = '{4'(i), 0, bit'(i % 2), kt[i], 1'b1, 4'(i),
                          1'b0, '0};
        end
        vecs[1].cs  = 1'b1;
        vecs[1].s   = {4'd7, 4'd3, 4'd1, 4'd0, 4'd0};
        vecs[16].cs = 1'b1;
        vecs[16].s  = {4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        vecs[17] = '{4'd0, 1, 1'b0, 5, 1'b0, 4'd15, 1'b1,
                     {4'd7, 4'd11, 4'd13, 4'd14, 4'd15}};
        vecs[18] = '{4'd9, 2, 1'b0, 4, 1'b0, 4'd15, 1'b1,
                     {4'd7, 4'd3, 4'd1, 4'd0, 4'd0}};

        #12;
        chk("rst_probe", probe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run(vecs[i].a, vecs[i].m, vecs[i].noisy);
            chk($sformatf("v%0d_k", i), k_o, vecs[i].k);
            chk($sformatf("v%0d_found", i), found, vecs[i].f);
            chk($sformatf("v%0d_result", i), result, vecs[i].r);
            chk($sformatf("v%0d_err", i), err, 0);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_p0", i), seq[0], 7);
            if (vecs[i].cs) begin
                for (int j = 1; j < vecs[i].k; j++)
                    chk($sformatf("v%0d_seq%0d", i, j), seq[j], vecs[i].s[j]);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse", i), done, 0);
        end

        a_h  = 4'd7;
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("stall_p0", probe, 7);
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
        @(posedge clk);
        #1;
        chk("chk_done", done, 1);
        chk("chk_err", err, 1);
        chk("chk_found", found, 0);
        chk("chk_busy", busy, 0);
`else
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_probe%0d", j), probe, 7);
            chk($sformatf("stall_done%0d", j), done, 0);
            chk($sformatf("stall_busy%0d", j), busy, 1);
        end
        mode = 0;
        @(posedge clk);
        #1;
        chk("stall_done", done, 1);
        chk("stall_found", found, 1);
        chk("stall_result", result, 7);
        chk("stall_err", err, 0);
`endif
        @(posedge clk);
        #1;

        a_h  = 4'd13;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ar_probe_pre", probe, 13);
        rst_n = 1'b0;
        #1;
        chk("ar_probe", probe, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_found", found, 0);
        chk("ar_result", result, 0);
        chk("ar_err", err, 0);
        @(posedge clk);
        #1;
        chk("ar_nodone", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'd13, 0, 1'b0);
        chk("ar_k", k_o, 3);
        chk("ar_found2", found, 1);
        chk("ar_result2", result, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
